regfile_sb: RTL

- Parametrised successor to the core's integer register file, for the pipelined NPC.
- Provides NUM_RD combinational read ports, one write-back port, hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register scoreboard: each register carries a pending bit, set when an instruction issues and cleared on write-back.
- Decode uses the per-port busy flags and issue_ready to stall on RAW/WAW hazards.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_sb.sv | 75 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded integer register file.
// Default widths, the hardwired-zero index and the read-port limit.
package regfile_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int REG_ZERO       = 0;
    localparam int NUM_RD_MAX     = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared on write-back.
// Drives issue_ready for WAW stalls and per-port rbusy for RAW stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    input  logic                         w_en,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    output logic                         issue_ready,
    output logic [NUM_RD-1:0]            rbusy,
    output logic [2**ADDR_WIDTH-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic [ADDR_WIDTH-1:0] ra;

    assign busy_vec = busy;

    always_comb begin
        issue_ready = !busy[issue_rd] || (w_en && (waddr == issue_rd));
    end

    // Clear first, then set, so a new producer wins over the old write-back.
    always_comb begin
        busy_nxt = busy;
        if (w_en && (waddr != ZERO))
            busy_nxt[waddr] = 1'b0;
        if (issue_valid && issue_ready && (issue_rd != ZERO))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_comb begin
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rbusy[i] = busy[ra] &&
                !((BYPASS != 0) && w_en && (waddr == ra));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD read ports, one write-back port,
// hardwired-zero r0, optional write-to-read bypass and a scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         w_en,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    output logic                         issue_ready,
    output logic [2**ADDR_WIDTH-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else if (w_en && (waddr != ZERO)) begin
            rf[waddr] <= wdata;
        end
    end

    // Bypass is masked in reset so rdata reads as zero throughout.
    always_comb begin
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (ra == ZERO)
                rd = '0;
            else if ((BYPASS != 0) && rstn && w_en && (waddr == ra))
                rd = wdata;
            else
                rd = rf[ra];
            rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rstn        (rstn),
        .raddr       (raddr),
        .w_en        (w_en),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rbusy       (rbusy),
        .busy_vec    (busy_vec)
    );

endmodule
